// File: rtl/branch_resolve_if.sv
// Branch resolve unit bus: fetch-side prediction push, execute-side
// resolution, BTB update / redirect outputs and optional statistics.
// The unit uses the slave modport; the fetch/execute side uses master.
interface branch_resolve_if #(
    parameter int PTR_BITS = 3
);
    logic                pred_valid;
    logic [31:0]         pred_pc;
    logic                pred_hit;
    logic [31:0]         pred_target;
    logic                pred_ready;
    logic                res_valid;
    logic                res_taken;
    logic [31:0]         res_target;
    logic                res_ready;
    logic                flush_in;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic                redirect;
    logic [31:0]         redirect_pc;
    logic [PTR_BITS:0]   occupancy;
    logic [31:0]         stat_resolved;
    logic [31:0]         stat_mispred;

    modport master (
        output pred_valid, pred_pc, pred_hit, pred_target,
        output res_valid, res_taken, res_target, flush_in,
        input  pred_ready, res_ready,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        input  redirect, redirect_pc, occupancy,
        input  stat_resolved, stat_mispred
    );

    modport slave (
        input  pred_valid, pred_pc, pred_hit, pred_target,
        input  res_valid, res_taken, res_target, flush_in,
        output pred_ready, res_ready,
        output upd_valid, upd_pc, upd_taken, upd_target,
        output redirect, redirect_pc, occupancy,
        output stat_resolved, stat_mispred
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetch-time BTB predictions.
// The oldest entry is compared against the execute-stage outcome; every
// resolve produces a registered BTB update, a mispredict additionally
// produces a one-cycle fetch redirect and discards all younger entries.
// Optional statistics counters are enabled with the macro BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_resolve_if.slave         bus
);

    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0] ONE_CNT  = (PTR_BITS+1)'(1);

    // Prediction storage (data only, never reset)
    logic [31:0]         pc_mem_q  [DEPTH];
    logic                hit_mem_q [DEPTH];
    logic [31:0]         tgt_mem_q [DEPTH];

    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q,  count_d;

    logic                upd_valid_q,   upd_valid_d;
    logic [31:0]         upd_pc_q,      upd_pc_d;
    logic                upd_taken_q,   upd_taken_d;
    logic [31:0]         upd_target_q,  upd_target_d;
    logic                redirect_q,    redirect_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;

    logic                full, empty, pred_ready;
    logic                push, pop, mispred, push_store;
    logic [31:0]         head_pc, head_tgt;
    logic                head_hit;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    // Wrong-path fetch is blocked while the redirect pulse is out
    assign pred_ready = !full && !redirect_q;

    assign head_pc  = pc_mem_q[rd_ptr_q];
    assign head_hit = hit_mem_q[rd_ptr_q];
    assign head_tgt = tgt_mem_q[rd_ptr_q];

    assign push = bus.pred_valid && pred_ready && !bus.flush_in;
    assign pop  = bus.res_valid && !empty && !bus.flush_in;

    assign mispred = (head_hit != bus.res_taken) ||
                     (head_hit && bus.res_taken && (head_tgt != bus.res_target));

    // A push coinciding with a mispredict is younger than the head and is dropped
    assign push_store = push && !(pop && mispred);

    // Write accepted predictions into the circular buffer
    always_ff @(posedge clk) begin
        if (push_store) begin
            pc_mem_q[wr_ptr_q]  <= bus.pred_pc;
            hit_mem_q[wr_ptr_q] <= bus.pred_hit;
            tgt_mem_q[wr_ptr_q] <= bus.pred_target;
        end
    end

    // Next-state for pointers, count and registered outputs
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        upd_valid_d   = 1'b0;
        redirect_d    = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        upd_target_d  = upd_target_q;
        redirect_pc_d = redirect_pc_q;

        if (bus.flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (pop && mispred) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            wr_ptr_d = rd_ptr_q + 1'b1;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + ONE_CNT;
            else if (pop && !push) count_d = count_q - ONE_CNT;
        end

        if (pop) begin
            upd_valid_d  = 1'b1;
            upd_pc_d     = head_pc;
            upd_taken_d  = bus.res_taken;
            upd_target_d = bus.res_target;
            if (mispred) begin
                redirect_d    = 1'b1;
                redirect_pc_d = bus.res_taken ? bus.res_target : head_pc + 32'd4;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_target_q  <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_target_q  <= upd_target_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] stat_resolved_q, stat_mispred_q;

    // Free-running wrap-around statistics; flush does not clear them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (pop)            stat_resolved_q <= stat_resolved_q + 32'd1;
            if (pop && mispred) stat_mispred_q  <= stat_mispred_q + 32'd1;
        end
    end

    assign bus.stat_resolved = stat_resolved_q;
    assign bus.stat_mispred  = stat_mispred_q;
`else
    assign bus.stat_resolved = '0;
    assign bus.stat_mispred  = '0;
`endif

    assign bus.pred_ready  = pred_ready;
    assign bus.res_ready   = !empty;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_pc      = upd_pc_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.upd_target  = upd_target_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.occupancy   = count_q;

endmodule
